ones_frame_accumulator: RTL

- Downstream consumer of the 8-bit ones-count stage.
- Accepts a stream of 8-bit data words over a valid/ready handshake and counts the set bits in each word (0..8).
- Accumulates those counts over a frame of up to FRAME_LEN words.
- Presents the frame total, the word count and the peak per-word count to the next stage over a valid/ready handshake.

---
 rtl/ones_pkg.sv | 30 +++
 rtl/ones_frame_accumulator_if.sv | 49 ++++
 rtl/popcount8.sv | 18 +
 rtl/ones_frame_accumulator.sv | 103 ++++++++++
 4 files changed

// File: rtl/ones_pkg.sv
// Shared types, widths and helpers for the ones-count frame accumulator.
//   state_t : frame FSM states
//   PC_W    : per-word popcount width (0..8 needs 4 bits)
//   DATA_W  : input word width
//   clog2   : ceiling log2, used for the derived total/word-count widths
package ones_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PC_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    // Number of bits needed to hold values 0..v-1 (v >= 1 gives >= 0).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ones_frame_accumulator_if.sv
// Word-in / frame-result-out handshake bundle for ones_frame_accumulator.
//   in_valid/in_ready/in_data/in_last      : upstream word stream
//   out_valid/out_ready/out_total/
//   out_words/out_peak                     : downstream frame result
// master = producer of words / consumer of results, slave = the accumulator.
interface ones_frame_accumulator_if #(
    parameter int unsigned FRAME_LEN = 16
) ();
    import ones_pkg::*;

    localparam int unsigned TOT_W = clog2(8 * FRAME_LEN + 1);
    localparam int unsigned WC_W  = clog2(FRAME_LEN + 1);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [TOT_W-1:0]  out_total;
    logic [WC_W-1:0]   out_words;
    logic [PC_W-1:0]   out_peak;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_total,
        input  out_words,
        input  out_peak
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_total,
        output out_words,
        output out_peak
    );

endinterface

// File: rtl/popcount8.sv
// Combinational set-bit count of one 8-bit word.
//   data    : input word
//   count_c : number of ones, 0..8 (4 bits so 0xFF yields 8)
module popcount8
    import ones_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [PC_W-1:0]   count_c
);

    always_comb begin
        count_c = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            count_c = count_c + PC_W'(data[i]);
        end
    end

endmodule

// File: rtl/ones_frame_accumulator.sv
// Accumulates per-word popcounts over a frame and hands the frame result on.
// A frame closes after FRAME_LEN accepted words or on an accepted in_last.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, discards any open frame
//   bus : slave side of ones_frame_accumulator_if
//         (in_valid/in_ready/in_data/in_last,
//          out_valid/out_ready/out_total/out_words/out_peak)
module ones_frame_accumulator
    import ones_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    ones_frame_accumulator_if.slave bus
);

    localparam int unsigned TOT_W = clog2(8 * FRAME_LEN + 1);
    localparam int unsigned WC_W  = clog2(FRAME_LEN + 1);

    state_t            state;
    logic [TOT_W-1:0]  acc;
    logic [WC_W-1:0]   words;
    logic [PC_W-1:0]   peak;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [PC_W-1:0]   pc_c;
    logic              accept_c;
    logic              close_c;
    logic [TOT_W-1:0]  acc_nxt_c;
    logic [WC_W-1:0]   words_nxt_c;
    logic [PC_W-1:0]   peak_nxt_c;

    popcount8 u_popcount8 (
        .data    (bus.in_data),
        .count_c (pc_c)
    );

    // Next accumulator values; IDLE starts a fresh frame from this word.
    always_comb begin
        accept_c    = bus.in_valid && in_ready_q;
        acc_nxt_c   = acc + TOT_W'(pc_c);
        words_nxt_c = words + WC_W'(1);
        peak_nxt_c  = (pc_c > peak) ? pc_c : peak;
        if (state == IDLE) begin
            acc_nxt_c   = TOT_W'(pc_c);
            words_nxt_c = WC_W'(1);
            peak_nxt_c  = pc_c;
        end
        // in_last and the length limit may coincide; either closes one frame.
        close_c = bus.in_last || (words_nxt_c == WC_W'(FRAME_LEN));
    end

    // Frame FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            acc         <= '0;
            words       <= '0;
            peak        <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept_c) begin
                        acc   <= acc_nxt_c;
                        words <= words_nxt_c;
                        peak  <= peak_nxt_c;
                        if (close_c) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // Accumulators stay put; the next frame's first word reloads them.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_total = acc;
    assign bus.out_words = words;
    assign bus.out_peak  = peak;

endmodule
